// File: rtl/ibex_register_file_fpga_scrub_if.sv
// Bus bundle for the scrubbing register file: read ports, the single write port,
// the setback request and the ready/clear-done status.
interface ibex_register_file_fpga_scrub_if #(
  parameter int unsigned NumReadPorts = 2,
  parameter int unsigned DataWidth    = 32
);
  logic                              setback_i;
  logic [NumReadPorts*5-1:0]         raddr_i;
  logic [NumReadPorts*DataWidth-1:0] rdata_o;
  logic [4:0]                        waddr_a_i;
  logic [DataWidth-1:0]              wdata_a_i;
  logic                              we_a_i;
  logic                              ready_o;
  logic                              clear_done_o;

  modport master (
    output setback_i, raddr_i, waddr_a_i, wdata_a_i, we_a_i,
    input  rdata_o, ready_o, clear_done_o
  );

  modport slave (
    input  setback_i, raddr_i, waddr_a_i, wdata_a_i, we_a_i,
    output rdata_o, ready_o, clear_done_o
  );
endinterface

// File: rtl/ibex_register_file_fpga_scrub.sv
// FPGA register file with an unreset distributed-RAM array that is zeroed by a
// sweep after reset or a setback request; reads return 0 until the sweep ends.
module ibex_register_file_fpga_scrub #(
  parameter bit          RV32E        = 1'b0,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned NumReadPorts = 2,
  parameter bit          WriteBypass  = 1'b0
) (
  input logic                          clk_i,
  input logic                          rst_ni,
  ibex_register_file_fpga_scrub_if.slave bus
);
  localparam int unsigned AddrWidth = RV32E ? 4 : 5;
  localparam int unsigned NumWords  = 2 ** AddrWidth;
  localparam logic [AddrWidth-1:0] LastAddr  = AddrWidth'(NumWords - 1);
  localparam logic [AddrWidth-1:0] FirstAddr = AddrWidth'(1);

  typedef enum logic {
    CLEAR,
    READY
  } state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   cnt_q, cnt_d;
  logic                   done_q, done_d;

  logic [DataWidth-1:0]   mem [NumWords];
  logic                   mem_we;
  logic [AddrWidth-1:0]   mem_waddr;
  logic [DataWidth-1:0]   mem_wdata;

  logic [AddrWidth-1:0]   waddr;
  logic                   user_we;
  logic                   ready;
  logic                   unused_addr_bits;

  // Only the low AddrWidth bits index the array; x0 is hardwired to zero.
  assign waddr            = bus.waddr_a_i[AddrWidth-1:0];
  assign user_we          = bus.we_a_i && (waddr != '0);
  assign ready            = (state_q == READY);
  assign unused_addr_bits = ^{bus.raddr_i, bus.waddr_a_i};

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdata = bus.wdata_a_i;

    unique case (state_q)
      CLEAR: begin
        // User writes are dropped; the scrubber owns the single write port.
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        if (bus.setback_i) begin
          cnt_d = FirstAddr;
        end else if (cnt_q == LastAddr) begin
          state_d = READY;
          cnt_d   = FirstAddr;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + FirstAddr;
        end
      end
      READY: begin
        mem_we = user_we;
        if (bus.setback_i) begin
          state_d = CLEAR;
          cnt_d   = FirstAddr;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CLEAR;
      cnt_q   <= FirstAddr;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // NOTE: the array has no reset so FPGA tools can map it to distributed RAM.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  for (genvar k = 0; k < NumReadPorts; k++) begin : g_read
    logic [AddrWidth-1:0] raddr;
    logic                 bypass;

    assign raddr  = bus.raddr_i[5*k +: AddrWidth];
    assign bypass = WriteBypass && ready && user_we && (raddr == waddr);
    assign bus.rdata_o[k*DataWidth +: DataWidth] =
        (!ready || (raddr == '0)) ? '0 :
        bypass                    ? bus.wdata_a_i :
                                    mem[raddr];
  end

  assign bus.ready_o      = ready;
  assign bus.clear_done_o = done_q;
endmodule
